// File: rtl/adc_spi_receiver.sv
// Receives the 16-bit MSB-first SPI control stream in the crystal_osc domain.
// Emits each word with a valid strobe and its slot index within a burst.
module adc_spi_receiver #(
    parameter int unsigned WORDS        = 3,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic        crystal_osc,
    input  logic        rstn,
    input  logic        adc_spi_clock,
    input  logic        adc_spi_data,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [1:0]  slot,
    output logic        frame_error,
    output logic        busy
);

    localparam int unsigned IW        = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
    localparam logic [1:0]  LAST_SLOT = 2'(WORDS - 1);

    logic          sclk_m_q, sclk_s_q, sclk_d_q;
    logic          sdat_m_q, sdat_s_q;
    logic          rise;

    logic [14:0]   shift_q,       shift_d;
    logic [3:0]    bit_count_q,   bit_count_d;
    logic [1:0]    slot_ptr_q,    slot_ptr_d;
    logic [IW-1:0] idle_q,        idle_d;
    logic [15:0]   data_q,        data_d;
    logic          data_valid_q,  data_valid_d;
    logic [1:0]    slot_q,        slot_d;
    logic          frame_error_q, frame_error_d;

    // Two-flop synchronisers; sclk gets a third flop for edge detection.
    always_ff @(posedge crystal_osc or negedge rstn) begin
        if (!rstn) begin
            sclk_m_q <= 1'b0;
            sclk_s_q <= 1'b0;
            sclk_d_q <= 1'b0;
            sdat_m_q <= 1'b0;
            sdat_s_q <= 1'b0;
        end else begin
            sclk_m_q <= adc_spi_clock;
            sclk_s_q <= sclk_m_q;
            sclk_d_q <= sclk_s_q;
            sdat_m_q <= adc_spi_data;
            sdat_s_q <= sdat_m_q;
        end
    end

    assign rise = sclk_s_q & ~sclk_d_q;

    always_comb begin
        shift_d       = shift_q;
        bit_count_d   = bit_count_q;
        slot_ptr_d    = slot_ptr_q;
        idle_d        = idle_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        slot_d        = slot_q;
        frame_error_d = 1'b0;

        if (rise) begin
            idle_d  = '0;
            shift_d = {shift_q[13:0], sdat_s_q};
            if (bit_count_q == 4'd15) begin
                data_d       = {shift_q, sdat_s_q};
                data_valid_d = 1'b1;
                slot_d       = slot_ptr_q;
                bit_count_d  = '0;
                slot_ptr_d   = (slot_ptr_q == LAST_SLOT) ? 2'd0 : slot_ptr_q + 2'd1;
            end else begin
                bit_count_d = bit_count_q + 4'd1;
            end
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
            // Reaching the saturation value is the single timeout event of this idle period.
            if (idle_q == IDLE_MAX - 1'b1) begin
                slot_ptr_d = '0;
                if (bit_count_q != 4'd0) begin
                    frame_error_d = 1'b1;
                    bit_count_d   = '0;
                    shift_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge crystal_osc or negedge rstn) begin
        if (!rstn) begin
            shift_q       <= '0;
            bit_count_q   <= '0;
            slot_ptr_q    <= '0;
            idle_q        <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            slot_q        <= '0;
            frame_error_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_count_q   <= bit_count_d;
            slot_ptr_q    <= slot_ptr_d;
            idle_q        <= idle_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            slot_q        <= slot_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = data_valid_q;
    assign slot        = slot_q;
    assign frame_error = frame_error_q;
    assign busy        = (bit_count_q != 4'd0);

endmodule

// File: doc/adc_spi_receiver.md
# adc_spi_receiver

Serial-to-parallel receiver for the 16-bit SPI control stream that enters the FPGA on `adc_spi_clock`/`adc_spi_data` from the external controller. It synchronises the asynchronous SPI clock and data into the `crystal_osc` domain and assembles MSB-first 16-bit words. Each word is presented with a one-cycle valid strobe and a slot index that places it within a burst of `WORDS` words. Truncated frames are discarded and flagged by an idle timeout. The block sits between the `top` SPI input pins and the parameter registers that feed the additive oscillator.

## Interface
Parameters:
- `WORDS`, 3, number of words per burst; slot index wraps modulo `WORDS` (range 1–4).
- `IDLE_TIMEOUT`, 64, count of `crystal_osc` cycles without an SPI rising edge that ends a frame or burst (range 8–1023).

Ports:
- `crystal_osc`  in  1  system clock (12.09 MHz OSCH); one clock, all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `adc_spi_clock`  in  1  SPI clock, asynchronous; idles low.
- `adc_spi_data`  in  1  SPI data, asynchronous; changes on the falling SCLK edge, sampled on the rising edge, MSB first.
- `data_out`  out  16  last complete word; holds its value until the next complete word.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `slot`  out  2  burst position of `data_out` (0..`WORDS`-1); valid whenever `data_valid` is high.
- `frame_error`  out  1  one-cycle pulse when a partial frame is aborted by timeout.
- `busy`  out  1  high while a frame is partially received (`bit_count` != 0).

## Operation
- Synchronisation:
  - `adc_spi_clock` and `adc_spi_data` each pass through a 2-FF synchroniser (`sclk_s`, `sdat_s`).
  - `sclk_s` is delayed one more flop (`sclk_d`).
  - `rise = sclk_s & ~sclk_d`.
  - Falling edges are ignored.
- Shift: on `rise`, `shift <= {shift[14:0], sdat_s}` and `bit_count` increments (4-bit counter).
- Word complete: on the `rise` where `bit_count` == 15:
  - `data_out <= {shift[14:0], sdat_s}`, `data_valid <= 1`, `slot <= slot_ptr`.
  - `bit_count <= 0`; `slot_ptr` advances, wrapping from `WORDS`-1 to 0.
- Idle counter:
  - Cleared on every `rise`; otherwise increments and saturates at `IDLE_TIMEOUT`.
  - Width is `$clog2(IDLE_TIMEOUT+1)`.
- Timeout event (the idle counter reaches `IDLE_TIMEOUT`, a single event per idle period):
  - If `bit_count` != 0: pulse `frame_error`, set `bit_count <= 0`, discard `shift`; `data_out` is unchanged.
  - In all cases: `slot_ptr <= 0`. An idle gap resynchronises the burst.
- States (implicit in `bit_count`/idle counter): IDLE (`bit_count` = 0) → RECEIVING (1..15) → IDLE on word complete or on timeout.
- Simultaneous events: `rise` in the same cycle the counter would reach `IDLE_TIMEOUT` — `rise` wins; no timeout occurs, the bit is shifted, and the counter clears.
- Frames longer than 16 bits: bit 17 onward starts a new word. There is no chip-select; framing relies on bit count and the idle gap only.
- Reset (asserted at any time, including mid-frame):
  - `data_out` = 0, `data_valid` = 0, `slot` = 0, `frame_error` = 0, `busy` = 0.
  - `shift`, `bit_count`, `slot_ptr`, idle counter, and all synchroniser flops = 0.
  - After release, any partial frame in progress is lost. A new frame is received correctly only if it starts after reset release.

## Timing
- `adc_spi_clock` rising pin edge → `rise` seen 2–3 `crystal_osc` edges later.
- 16th rising edge → `data_valid` high 3–4 `crystal_osc` cycles later, for exactly 1 cycle.
- Minimum SCLK high and low time: 3 `crystal_osc` periods (≈250 ns).
  - Bench SPI (375 ns half-period) has ≈4.5 cycles per half-period and is compliant.
- `sdat_s` is sampled in the same cycle as `rise`. Data is therefore captured about 3 cycles after the pin rising edge, and is stable at that point because data changes only on the falling edge.
- `frame_error` fires `IDLE_TIMEOUT` cycles (+0/+3 for synchroniser skew) after the last rising edge.
- `busy` rises in the cycle after the first `rise` and falls in the cycle after word complete or timeout.

## Test plan
- Reset hold 20 ns, then release → all outputs 0. No activity for 1000 cycles → `frame_error` never pulses (`bit_count` = 0).
- Send 0x96AA at 750 ns per bit → single `data_valid` pulse with `data_out` = 0x96AA, `slot` = 0; `busy` low afterwards.
- Send burst 0x96AA, 0x5533, 0x1655 back-to-back, then a 4th word 0xAACC without a gap → slots 0, 1, 2, 0 respectively, each with exactly one `data_valid` pulse.
- Send 15 bits of 0x96AA (truncated), then idle ≥ `IDLE_TIMEOUT` → one `frame_error` pulse, no `data_valid`, `data_out` keeps its previous value. Then send 0x5533 → `data_out` = 0x5533, `slot` = 0.
- Send 0x96AA, idle gap > `IDLE_TIMEOUT`, then 0x5533 → `slot` 0 then 0 (gap resets the burst), with no `frame_error`.
- Assert `rstn` low after 8 bits of 0x96AA, release, then send 0x1655 → `data_out` = 0x1655, `slot` = 0, and no `frame_error` caused by the aborted frame.
